// File: rtl/ws2812b_pkg.sv
// Shared types and constants for the ws2812b frame loader.
package ws2812b_pkg;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_IDX   = 3'd1,
        ST_B2    = 3'd2,
        ST_B1    = 3'd3,
        ST_B0    = 3'd4,
        ST_CHK   = 3'd5,
        ST_WRITE = 3'd6,
        ST_BCAST = 3'd7
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] BCAST_IDX  = 8'hFF;

    // Packet checksum: XOR of the index and the three colour bytes.
    function automatic logic [7:0] packet_checksum(input logic [7:0] idx,
                                                   input logic [7:0] c2,
                                                   input logic [7:0] c1,
                                                   input logic [7:0] c0);
        return idx ^ c2 ^ c1 ^ c0;
    endfunction

endpackage

// File: rtl/ws2812b_frame_loader_if.sv
// Byte-stream input and frame-buffer write port of the frame loader.
interface ws2812b_frame_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] color;
    logic [31:0] nb_led;
    logic        write;

    modport master (
        output in_data, in_valid,
        input  in_ready, color, nb_led, write
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, color, nb_led, write
    );
endinterface

// File: rtl/ws2812b_byte_timeout.sv
// Restartable inter-byte timeout: down-counter reloaded by clr_i, one-cycle expiry pulse.
module ws2812b_byte_timeout #(
    parameter int unsigned LIMIT = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0] LOAD = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reload on clear, otherwise count down while enabled and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= LOAD;
        else     cnt_q <= cnt_d;
    end

    // The last counting cycle expires unless a byte restarts the window in it.
    assign expire_o = en_i && !clr_i && (cnt_q == CW'(1));

endmodule

// File: rtl/ws2812b_frame_loader.sv
// Parses SYNC/index/C2/C1/C0/checksum packets into frame-buffer writes.
//
// state | meaning
// HUNT  | discard bytes until SYNC
// IDX   | waiting for LED index
// B2    | waiting for first colour byte
// B1    | waiting for second colour byte
// B0    | waiting for third colour byte
// CHK   | waiting for checksum, decide write/broadcast/error
// WRITE | single write strobe
// BCAST | write strobe per LED, nb_led 0..NB_LEDS-1
module ws2812b_frame_loader
    import ws2812b_pkg::*;
#(
    parameter int unsigned FCLK       = 100,
    parameter int unsigned NB_LEDS    = 5,
    parameter logic [7:0]  SYNC       = SYNC_BYTE,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    ws2812b_frame_loader_if.slave        loader_if,
    output logic                         err_checksum_o,
    output logic                         err_index_o,
    output logic                         err_timeout_o,
    output logic [15:0]                  frames_ok_o
);
    localparam int unsigned LIMIT    = TIMEOUT_US * FCLK;
    localparam logic [7:0]  LAST_LED = 8'(NB_LEDS - 1);

    loader_state_e state_q, state_d;

    logic [7:0]  idx_q, c2_q, c1_q, c0_q;
    logic [23:0] color_q;
    logic [7:0]  nb_led_q;
    logic [15:0] frames_ok_q;
    logic        err_checksum_q, err_index_q, err_timeout_q;

    logic busy;
    logic accept;
    logic chk_ok;
    logic count_en;
    logic to_clr;
    logic to_expire;
    logic set_err_chk, set_err_idx, set_err_to;
    logic load_write, load_bcast, frame_done;

    assign busy     = (state_q == ST_WRITE) || (state_q == ST_BCAST);
    assign accept   = loader_if.in_valid && loader_if.in_ready;
    assign chk_ok   = (packet_checksum(idx_q, c2_q, c1_q, c0_q) == loader_if.in_data);
    assign count_en = state_q inside {ST_IDX, ST_B2, ST_B1, ST_B0, ST_CHK};
    // Outside the packet states the window is held at its full length.
    assign to_clr   = accept || !count_en;

    ws2812b_byte_timeout #(
        .LIMIT (LIMIT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (to_clr),
        .en_i     (count_en),
        .expire_o (to_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_HUNT;
        else     state_q <= state_d;
    end

    // Next-state decode and datapath/error control strobes.
    always_comb begin
        state_d     = state_q;
        set_err_chk = 1'b0;
        set_err_idx = 1'b0;
        set_err_to  = 1'b0;
        load_write  = 1'b0;
        load_bcast  = 1'b0;
        frame_done  = 1'b0;
        unique case (state_q)
            ST_HUNT: begin
                if (accept && (loader_if.in_data == SYNC)) state_d = ST_IDX;
            end
            ST_IDX, ST_B2, ST_B1, ST_B0: begin
                if (accept) begin
                    state_d = loader_state_e'(state_q + 3'd1);
                end else if (to_expire) begin
                    state_d    = ST_HUNT;
                    set_err_to = 1'b1;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    state_d = ST_HUNT;
                    if (!chk_ok) begin
                        set_err_chk = 1'b1;
                    end else if (idx_q <= LAST_LED) begin
                        state_d    = ST_WRITE;
                        load_write = 1'b1;
                    end else if (idx_q == BCAST_IDX) begin
                        state_d    = ST_BCAST;
                        load_bcast = 1'b1;
                    end else begin
                        set_err_idx = 1'b1;
                    end
                end else if (to_expire) begin
                    state_d    = ST_HUNT;
                    set_err_to = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d    = ST_HUNT;
                frame_done = 1'b1;
            end
            ST_BCAST: begin
                if (nb_led_q == LAST_LED) begin
                    state_d    = ST_HUNT;
                    frame_done = 1'b1;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    // Packet capture, output hold registers, error pulses and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q          <= '0;
            c2_q           <= '0;
            c1_q           <= '0;
            c0_q           <= '0;
            color_q        <= '0;
            nb_led_q       <= '0;
            frames_ok_q    <= '0;
            err_checksum_q <= 1'b0;
            err_index_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            err_checksum_q <= set_err_chk;
            err_index_q    <= set_err_idx;
            err_timeout_q  <= set_err_to;
            if (accept) begin
                if (state_q == ST_IDX) idx_q <= loader_if.in_data;
                if (state_q == ST_B2)  c2_q  <= loader_if.in_data;
                if (state_q == ST_B1)  c1_q  <= loader_if.in_data;
                if (state_q == ST_B0)  c0_q  <= loader_if.in_data;
            end
            if (load_write) begin
                color_q  <= {c2_q, c1_q, c0_q};
                nb_led_q <= idx_q;
            end else if (load_bcast) begin
                color_q  <= {c2_q, c1_q, c0_q};
                nb_led_q <= '0;
            end else if ((state_q == ST_BCAST) && (nb_led_q != LAST_LED)) begin
                nb_led_q <= nb_led_q + 8'd1;
            end
            if (frame_done) frames_ok_q <= frames_ok_q + 16'd1;
        end
    end

    // Strobe and ready are forced low while reset is asserted.
    assign loader_if.in_ready = !rst && !busy;
    assign loader_if.write    = !rst && busy;
    assign loader_if.color    = color_q;
    assign loader_if.nb_led   = {24'd0, nb_led_q};
    assign err_checksum_o     = err_checksum_q;
    assign err_index_o        = err_index_q;
    assign err_timeout_o      = err_timeout_q;
    assign frames_ok_o        = frames_ok_q;

endmodule

// File: tb/tb_ws2812b_frame_loader.sv
// Directed self-checking bench for ws2812b_frame_loader.
module tb_ws2812b_frame_loader;
    localparam int LIMIT = 20;   // TIMEOUT_US(20) * FCLK(1)

    logic        clk;
    logic        rst;
    logic        err_checksum, err_index, err_timeout;
    logic [15:0] frames_ok;

    ws2812b_frame_loader_if bus();

    ws2812b_frame_loader #(
        .FCLK       (1),
        .NB_LEDS    (5),
        .SYNC       (8'hA5),
        .TIMEOUT_US (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .loader_if      (bus),
        .err_checksum_o (err_checksum),
        .err_index_o    (err_index),
        .err_timeout_o  (err_timeout),
        .frames_ok_o    (frames_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mon_nb[$];
    logic [23:0] mon_col[$];
    int n_ecs = 0, n_eidx = 0, n_eto = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every write strobe and error pulse; flag illegal overlaps.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write) begin
                mon_nb.push_back(bus.nb_led);
                mon_col.push_back(bus.color);
                if (bus.in_ready) n_bad++;
                if (err_checksum || err_index || err_timeout) n_bad++;
            end
            if (int'(err_checksum) + int'(err_index) + int'(err_timeout) > 1) n_bad++;
            if (err_checksum) n_ecs++;
            if (err_index)    n_eidx++;
            if (err_timeout)  n_eto++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep);
        bit ok;
        ok = 1'b0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        check_eq("byte_accepted", {31'd0, ok}, 32'd1);
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [47:0] pkt, input bit keep);
        for (int i = 5; i >= 0; i--) begin
            send_byte(pkt[i*8 +: 8], (i != 0) || keep);
        end
    endtask

    int base;
    int eb;
    int n;

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        check_eq("rst_write_low", {31'd0, bus.write}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("rst_color", {8'd0, bus.color}, 32'd0);
        check_eq("rst_nb_led", bus.nb_led, 32'd0);
        check_eq("rst_frames", {16'd0, frames_ok}, 32'd0);
        check_eq("rst_errs", {29'd0, err_checksum, err_index, err_timeout}, 32'd0);

        // Single write to LED 2.
        base = mon_nb.size();
        send_pkt(48'hA5_02_11_22_33_02, 1'b0);
        check_eq("single_write", {31'd0, bus.write}, 32'd1);
        check_eq("single_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("single_nb_led", bus.nb_led, 32'd2);
        check_eq("single_color", {8'd0, bus.color}, 32'h00112233);
        step();
        check_eq("single_write_end", {31'd0, bus.write}, 32'd0);
        check_eq("single_frames", {16'd0, frames_ok}, 32'd1);
        check_eq("single_hold_color", {8'd0, bus.color}, 32'h00112233);
        check_eq("single_wcount", mon_nb.size() - base, 32'd1);

        // Bad checksum, then a valid packet for LED 1.
        base = mon_nb.size();
        eb   = n_ecs;
        send_pkt(48'hA5_01_FF_00_00_00, 1'b0);
        check_eq("badchk_pulse", {31'd0, err_checksum}, 32'd1);
        check_eq("badchk_write", {31'd0, bus.write}, 32'd0);
        step();
        check_eq("badchk_pulse_end", {31'd0, err_checksum}, 32'd0);
        send_pkt(48'hA5_01_AA_BB_CC_DC, 1'b0);
        check_eq("led1_write", {31'd0, bus.write}, 32'd1);
        check_eq("led1_nb_led", bus.nb_led, 32'd1);
        check_eq("led1_color", {8'd0, bus.color}, 32'h00AABBCC);
        step();
        check_eq("led1_frames", {16'd0, frames_ok}, 32'd2);
        check_eq("badchk_wcount", mon_nb.size() - base, 32'd1);
        check_eq("badchk_count", n_ecs - eb, 32'd1);

        // Out-of-range index.
        base = mon_nb.size();
        eb   = n_eidx;
        send_pkt(48'hA5_07_00_00_00_07, 1'b0);
        check_eq("badidx_pulse", {31'd0, err_index}, 32'd1);
        check_eq("badidx_write", {31'd0, bus.write}, 32'd0);
        check_eq("badidx_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        check_eq("badidx_pulse_end", {31'd0, err_index}, 32'd0);
        check_eq("badidx_count", n_eidx - eb, 32'd1);
        check_eq("badidx_wcount", mon_nb.size() - base, 32'd0);
        check_eq("badidx_frames", {16'd0, frames_ok}, 32'd2);

        // Broadcast green to all five LEDs.
        send_pkt(48'hA5_FF_00_FF_00_00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_eq("bcast_write", {31'd0, bus.write}, 32'd1);
            check_eq("bcast_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_eq("bcast_nb_led", bus.nb_led, 32'(i));
            check_eq("bcast_color", {8'd0, bus.color}, 32'h0000FF00);
            step();
        end
        check_eq("bcast_write_end", {31'd0, bus.write}, 32'd0);
        check_eq("bcast_frames", {16'd0, frames_ok}, 32'd3);

        // Noise before SYNC, then a stalled packet.
        base = mon_nb.size();
        eb   = n_eto;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h03, 1'b0);
        n = 0;
        while (!err_timeout && n < LIMIT + 10) begin
            step();
            n++;
        end
        check_eq("timeout_latency", n, LIMIT);
        step();
        check_eq("timeout_pulse_end", {31'd0, err_timeout}, 32'd0);
        check_eq("timeout_count", n_eto - eb, 32'd1);
        check_eq("noise_wcount", mon_nb.size() - base, 32'd0);
        check_eq("noise_other_errs", n_ecs + n_eidx, 32'd2);

        // Byte arriving in the last cycle of the window wins over the timeout.
        eb = n_eto;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        repeat (LIMIT - 1) step();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        check_eq("edge_write", {31'd0, bus.write}, 32'd1);
        check_eq("edge_nb_led", bus.nb_led, 32'd4);
        check_eq("edge_color", {8'd0, bus.color}, 32'h00010203);
        step();
        check_eq("edge_no_timeout", n_eto - eb, 32'd0);
        check_eq("edge_frames", {16'd0, frames_ok}, 32'd4);

        // Back-to-back packets with in_valid held high; SYNC value used as data.
        base = mon_nb.size();
        send_pkt(48'hA5_00_01_02_03_00, 1'b1);
        send_pkt(48'hA5_01_A5_A5_00_01, 1'b1);
        send_pkt(48'hA5_03_10_20_30_03, 1'b0);
        repeat (3) step();
        check_eq("b2b_wcount", mon_nb.size() - base, 32'd3);
        if (mon_nb.size() - base == 3) begin
            check_eq("b2b_nb0", mon_nb[base], 32'd0);
            check_eq("b2b_col0", {8'd0, mon_col[base]}, 32'h00010203);
            check_eq("b2b_nb1", mon_nb[base+1], 32'd1);
            check_eq("b2b_col1", {8'd0, mon_col[base+1]}, 32'h00A5A500);
            check_eq("b2b_nb2", mon_nb[base+2], 32'd3);
            check_eq("b2b_col2", {8'd0, mon_col[base+2]}, 32'h00102030);
        end
        check_eq("b2b_frames", {16'd0, frames_ok}, 32'd7);

        // Reset during the third broadcast write.
        send_pkt(48'hA5_FF_12_34_56_8F, 1'b0);
        step();
        step();
        check_eq("rstb_write3", {31'd0, bus.write}, 32'd1);
        check_eq("rstb_nb_led3", bus.nb_led, 32'd2);
        rst  = 1'b1;
        base = mon_nb.size();
        step();
        check_eq("rstb_write_off", {31'd0, bus.write}, 32'd0);
        check_eq("rstb_frames", {16'd0, frames_ok}, 32'd0);
        rst = 1'b0;
        step();
        check_eq("rstb_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_eq("rstb_nb_led", bus.nb_led, 32'd0);
        check_eq("rstb_color", {8'd0, bus.color}, 32'd0);
        repeat (8) step();
        check_eq("rstb_no_writes", mon_nb.size() - base, 32'd0);
        check_eq("rstb_write_idle", {31'd0, bus.write}, 32'd0);

        check_eq("overlap_violations", n_bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1, "global timeout");
    end

endmodule
